uart_matrix_sender: RTL and testbench
=====================================

// Module: uart_matrix_sender
// PURPOSE
//  Transmit-side counterpart of uart_cmd_parser: reads one stored matrix element by element and
//  emits it as ASCII text bytes into uart_tx. Sits between matrix_storage (read port) and
//  uart_tx (byte handshake); started by ctrl_fsm in display/output modes.
//  Output text: header "M<id> <m>x<n>\r\n", then rows of decimal elements, ' ' between, "\r\n" per row.
// PARAMETERS
//  MAX_DIM   5   largest legal row/column count
//  ADDR_W    5   storage element address width (holds MAX_DIM*MAX_DIM-1)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       one-cycle request to send a matrix; ignored while busy
//  matrix_id  in   4       matrix id to send (header digit, hex 0-F)
//  dim_m      in   3       rows, sampled on start
//  dim_n      in   3       columns, sampled on start
//  rd_en      out  1       one-cycle element read strobe to storage
//  rd_addr    out  ADDR_W  element address = row*dim_n + col (row-major)
//  rd_data    in   8       element value, unsigned
//  rd_valid   in   1       rd_data valid; arrives >=1 cycle after rd_en
//  tx_data    out  8       byte for uart_tx, stable while tx_start high
//  tx_start   out  1       one-cycle byte launch strobe
//  tx_busy    in   1       uart_tx serialising; high from cycle after tx_start until stop bit done
//  busy       out  1       high from accepted start until done
//  done       out  1       one-cycle pulse after last '\n' fully sent
//  error      out  1       one-cycle pulse on illegal dimensions
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-transfer aborts at once; tx_start drops.
//  IDLE: start && dims legal -> latch id/m/n, busy=1, -> HDR. dim 0 or >MAX_DIM -> error pulse
//   next cycle, stay IDLE, no rd_en/tx_start.
//  HDR: sends 'M', hex(id) ('0'-'9','A'-'F'), ' ', '0'+m, 'x', '0'+n, 8'h0D, 8'h0A.
//  FETCH: rd_en=1 one cycle with rd_addr -> WAIT_RD; hold until rd_valid, latch rd_data.
//  DIGITS: value split by bin2bcd8; leading zeros suppressed (0 -> "0", 7 -> "7", 100 -> "100",
//   255 -> "255"); digits sent MSD first as '0'+d.
//  SEP: col<n-1 -> send ' ', col++ , -> FETCH; col==n-1 -> send 8'h0D then 8'h0A, col=0, row++;
//   row==m-1 at end of row -> DONE.
//  DONE: wait tx_busy==0 after final byte, pulse done, busy=0, -> IDLE. No trailing space.
//  Byte handshake (every byte): tx_start only when tx_busy==0 and not in the cycle directly after
//   a previous tx_start (one guard cycle so uart_tx can raise tx_busy); tx_data set in same cycle.
//   Exactly one tx_start per byte; tx_busy stuck high -> stall indefinitely, no byte lost.
//  Latency: first tx_start 1 cycle after accepted start (tx_busy low). rd_en never issued while
//   a previous read is outstanding. Total bytes = 8 + sum(digits) + m*(n-1) + 2m.
//  start during busy: ignored, no effect on in-flight transfer. rd_valid while not waiting: ignored.
//  Address arithmetic: row*dim_n + col computed at ADDR_W bits; max 24 for 5x5, no wrap.
// STRUCTURE
//  Shared package: ASCII constants (CR=8'h0D, LF=8'h0A, SP=8'h20, '0', 'M', 'x'), MAX_DIM,
//   state enum shared with uart_cmd_parser's dimension rules.
//  Sub-module bin2bcd8: combinational 8-bit -> hundreds/tens/ones (compare-subtract), reused by
//   seg_display. Rest is one FSM plus row/col/digit counters.
// TESTING
//  id=3, 2x2, elements {1,23,200,0}, tx_busy 10 cycles per byte -> bytes "M3 2x2\r\n1 23\r\n200 0\r\n",
//   done once, 21 tx_start pulses total.
//  1x3 {0,100,255} -> "M.. 1x3\r\n0 100 255\r\n"; id=10 header shows 'A'.
//  dim_m=0 or dim_n=6 with start -> error pulse, busy stays 0, no rd_en, no tx_start.
//  rd_valid delayed 5 cycles per read -> no extra rd_en, output bytes unchanged.
//  start pulsed mid-transfer and tx_busy held high 1000 cycles -> output identical, no duplicate byte.
//  rst_n low during row 2 -> tx_start/busy/rd_en 0 immediately; new start afterwards sends full matrix.

Source files
------------

// File: rtl/uart_matrix_sender_pkg.sv
// Shared constants, state encoding and small helpers for the matrix text sender.
// Dimension legality here matches the rules the command parser applies.
package uart_matrix_sender_pkg;

  localparam int DEF_MAX_DIM = 5;
  localparam int DEF_ADDR_W  = 5;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_M  = 8'h4D;
  localparam logic [7:0] ASC_X  = 8'h78;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_WAIT_RD,
    S_DIGITS,
    S_SEP,
    S_DONE
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (ASC_0 + {4'd0, v}) : (ASC_A + {4'd0, v} - 8'd10);
  endfunction

  function automatic logic dim_legal(input logic [2:0] d, input int max_dim);
    return (d != 3'd0) && (int'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/uart_matrix_sender_bin2bcd8.sv
// Combinational 8-bit binary to hundreds/tens/ones split by compare-subtract.
module bin2bcd8 (
  input  logic [7:0] value,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0] rem;

  always_comb begin
    rem      = value;
    hundreds = 4'd0;
    tens     = 4'd0;
    if (rem >= 8'd200) begin
      hundreds = 4'd2;
      rem      = rem - 8'd200;
    end else if (rem >= 8'd100) begin
      hundreds = 4'd1;
      rem      = rem - 8'd100;
    end
    for (int i = 0; i < 9; i++) begin
      if (rem >= 8'd10) begin
        rem  = rem - 8'd10;
        tens = tens + 4'd1;
      end
    end
    ones = rem[3:0];
  end

endmodule

// File: rtl/uart_matrix_sender.sv
// Streams one stored matrix as ASCII text: "M<id> <m>x<n>\r\n" then rows of decimal elements.
//
//  state     | meaning
//  S_IDLE    | waiting for start; illegal dims raise a one-cycle error
//  S_HDR     | sending the 8 header bytes
//  S_FETCH   | one-cycle read strobe for element (row, col)
//  S_WAIT_RD | waiting for rd_valid, latches element
//  S_DIGITS  | sending element digits, most significant first
//  S_SEP     | sending ' ' between columns or CR LF at row end
//  S_DONE    | waiting for the last byte to drain, then pulses done
module uart_matrix_sender
  import uart_matrix_sender_pkg::*;
#(
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        matrix_id,
  input  logic [2:0]        dim_m,
  input  logic [2:0]        dim_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic              rd_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t      state_q, state_d;
  logic [3:0]  id_q;
  logic [2:0]  m_q, n_q, row_q, col_q, hdr_idx_q;
  logic [1:0]  dig_left_q, ndig;
  logic [7:0]  value_q, bcd_in, byte_val;
  logic        lf_phase_q, guard_q, error_q;
  logic [3:0]  hundreds, tens, ones, dig;
  logic        start_ok, can_send, last_col, last_row, byte_req;

  // During WAIT_RD the splitter sees the incoming element so the digit count is ready on latch.
  assign bcd_in = (state_q == S_WAIT_RD) ? rd_data : value_q;

  bin2bcd8 u_bcd (
    .value    (bcd_in),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  assign ndig     = (hundreds != 4'd0) ? 2'd2 : ((tens != 4'd0) ? 2'd1 : 2'd0);
  assign dig      = (dig_left_q == 2'd2) ? hundreds : ((dig_left_q == 2'd1) ? tens : ones);
  assign start_ok = dim_legal(dim_m, MAX_DIM) && dim_legal(dim_n, MAX_DIM);
  // guard_q keeps one idle cycle after each launch so uart_tx can raise tx_busy.
  assign can_send = !tx_busy && !guard_q;
  assign last_col = (col_q == n_q - 3'd1);
  assign last_row = (row_q == m_q - 3'd1);
  assign rd_addr  = ADDR_W'(row_q) * ADDR_W'(n_q) + ADDR_W'(col_q);
  assign tx_start = byte_req && can_send;
  assign tx_data  = tx_start ? byte_val : 8'h00;
  assign busy     = (state_q != S_IDLE);
  assign error    = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    byte_req = 1'b0;
    byte_val = 8'h00;
    rd_en    = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: if (start && start_ok) state_d = S_HDR;
      S_HDR: begin
        byte_req = 1'b1;
        case (hdr_idx_q)
          3'd0:    byte_val = ASC_M;
          3'd1:    byte_val = hex_ascii(id_q);
          3'd2:    byte_val = ASC_SP;
          3'd3:    byte_val = ASC_0 + {5'd0, m_q};
          3'd4:    byte_val = ASC_X;
          3'd5:    byte_val = ASC_0 + {5'd0, n_q};
          3'd6:    byte_val = ASC_CR;
          default: byte_val = ASC_LF;
        endcase
        if (can_send && hdr_idx_q == 3'd7) state_d = S_FETCH;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: if (rd_valid) state_d = S_DIGITS;
      S_DIGITS: begin
        byte_req = 1'b1;
        byte_val = ASC_0 + {4'd0, dig};
        if (can_send && dig_left_q == 2'd0) state_d = S_SEP;
      end
      S_SEP: begin
        byte_req = 1'b1;
        if (!last_col) begin
          byte_val = ASC_SP;
          if (can_send) state_d = S_FETCH;
        end else begin
          byte_val = lf_phase_q ? ASC_LF : ASC_CR;
          if (can_send && lf_phase_q) state_d = last_row ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        if (can_send) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= 4'd0;
      m_q        <= 3'd0;
      n_q        <= 3'd0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      hdr_idx_q  <= 3'd0;
      dig_left_q <= 2'd0;
      value_q    <= 8'd0;
      lf_phase_q <= 1'b0;
      guard_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      guard_q <= tx_start;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              id_q       <= matrix_id;
              m_q        <= dim_m;
              n_q        <= dim_n;
              row_q      <= 3'd0;
              col_q      <= 3'd0;
              hdr_idx_q  <= 3'd0;
              lf_phase_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        S_HDR: if (tx_start) hdr_idx_q <= hdr_idx_q + 3'd1;
        S_WAIT_RD: begin
          if (rd_valid) begin
            value_q    <= rd_data;
            dig_left_q <= ndig;
          end
        end
        S_DIGITS: if (tx_start) dig_left_q <= dig_left_q - 2'd1;
        S_SEP: begin
          if (tx_start) begin
            if (!last_col) begin
              col_q <= col_q + 3'd1;
            end else if (!lf_phase_q) begin
              lf_phase_q <= 1'b1;
            end else begin
              lf_phase_q <= 1'b0;
              col_q      <= 3'd0;
              row_q      <= row_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_matrix_sender.sv
// Bench for uart_matrix_sender: storage and uart_tx models, table vectors, random matrices.
module tb_uart_matrix_sender;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] matrix_id = 4'd0;
  logic [2:0] dim_m = 3'd0, dim_n = 3'd0;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_data = 8'd0;
  logic       rd_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       busy, done, error;

  uart_matrix_sender dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .matrix_id (matrix_id),
    .dim_m     (dim_m),
    .dim_n     (dim_n),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] mem[32];
  logic [7:0] got_q[$], exp_q[$];
  int  busy_len = 0, rd_lat = 1;
  bit  force_busy = 0, spurious = 0;
  int  done_cnt = 0, err_cnt = 0, tx_cnt = 0, rd_cnt = 0, busy_cyc = 0;
  int  done_base = 0, tx_base = 0;
  bit  start_seen = 0, rd_out = 0, prev_tx = 0;
  int  busy_left = 0, lat_left = 0;
  logic [4:0] rd_addr_q = 5'd0;

  typedef struct {
    int    id;
    int    m;
    int    n;
    int    el[9];
    int    blen;
    int    lat;
    bit    bad;
    string text;   // '|' stands for CR LF
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Byte sink and storage request monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      got_q.push_back(tx_data);
      tx_cnt++;
      start_seen = 1;
      check("tx_start_while_busy", int'(tx_busy), 0);
      check("tx_guard_cycle", int'(prev_tx), 0);
    end
    prev_tx = tx_start;
    if (done)  done_cnt++;
    if (error) err_cnt++;
    if (busy)  busy_cyc++;
    if (rd_en) begin
      rd_cnt++;
      check("rd_overlap", int'(rd_out), 0);
      rd_out    = 1;
      rd_addr_q = rd_addr;
      lat_left  = rd_lat;
    end
  end

  // uart_tx busy and storage response drivers, updated just after the clock edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (start_seen) begin
      busy_left  = busy_len;
      start_seen = 0;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    tx_busy  = force_busy || (busy_left > 0);
    rd_valid = 1'b0;
    rd_data  = 8'($urandom);
    if (rd_out) begin
      if (lat_left <= 1) begin
        rd_valid = 1'b1;
        rd_data  = mem[rd_addr_q];
        rd_out   = 0;
      end else begin
        lat_left--;
      end
    end else if (spurious && $urandom_range(0, 3) == 0) begin
      rd_valid = 1'b1;
    end
  end

  task automatic load_text(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h7C) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end else begin
        exp_q.push_back(8'(s[i]));
      end
    end
  endtask

  // Reference: format the matrix as text directly from its element values.
  task automatic model_expect(input int id, input int m, input int n);
    string s, hexd, letters;
    letters = "ABCDEF";
    hexd = (id < 10) ? $sformatf("%0d", id) : letters.substr(id - 10, id - 10);
    s = $sformatf("M%s %0dx%0d|", hexd, m, n);
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = {s, $sformatf("%0d", mem[r * n + c])};
        if (c < n - 1) s = {s, " "};
      end
      s = {s, "|"};
    end
    load_text(s);
  endtask

  task automatic begin_xfer(input int id, input int m, input int n);
    got_q.delete();
    done_base = done_cnt;
    tx_base   = tx_cnt;
    @(posedge clk); #1;
    matrix_id = 4'(id);
    dim_m     = 3'(m);
    dim_n     = 3'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("first_byte_latency", int'(tx_start), 1);
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic finish_xfer(input string name);
    int waited = 0;
    while (done_cnt == done_base && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_done_timeout"}, int'(waited < 6000), 1);
    repeat (3) @(negedge clk);
    check({name, "_done_count"}, done_cnt - done_base, 1);
    check({name, "_busy_end"}, int'(busy), 0);
    check({name, "_byte_count"}, got_q.size(), exp_q.size());
    check({name, "_tx_starts"}, tx_cnt - tx_base, exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
  endtask

  task automatic err_xfer(input string name, input int m, input int n);
    int eb, rb, tb, bb;
    eb = err_cnt; rb = rd_cnt; tb = tx_cnt; bb = busy_cyc;
    @(posedge clk); #1;
    dim_m = 3'(m);
    dim_n = 3'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({name, "_error_next_cycle"}, int'(error), 1);
    repeat (10) @(negedge clk);
    check({name, "_error_pulses"}, err_cnt - eb, 1);
    check({name, "_no_rd_en"}, rd_cnt - rb, 0);
    check({name, "_no_tx_start"}, tx_cnt - tb, 0);
    check({name, "_busy_stays_low"}, busy_cyc - bb, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc, base;

    vecs[0] = '{3,  2, 2, '{1, 23, 200, 0, 0, 0, 0, 0, 0}, 10, 1, 0, "M3 2x2|1 23|200 0|"};
    vecs[1] = '{10, 1, 3, '{0, 100, 255, 0, 0, 0, 0, 0, 0}, 3, 1, 0, "MA 1x3|0 100 255|"};
    vecs[2] = '{15, 1, 1, '{7, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 5, 0, "MF 1x1|7|"};
    vecs[3] = '{0,  0, 2, '{0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 1, 1, ""};
    vecs[4] = '{1,  2, 6, '{0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 1, 1, ""};
    vecs[5] = '{2,  3, 1, '{9, 10, 99, 0, 0, 0, 0, 0, 0}, 2, 5, 0, "M2 3x1|9|10|99|"};
    vecs[6] = '{3,  2, 2, '{1, 23, 200, 0, 0, 0, 0, 0, 0}, 10, 5, 0, "M3 2x2|1 23|200 0|"};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_tx_start", int'(tx_start), 0);
    check("reset_rd_en", int'(rd_en), 0);
    check("reset_done", int'(done), 0);
    check("reset_error", int'(error), 0);
    check("reset_rd_addr", int'(rd_addr), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[v]) begin
      if (vecs[v].bad) begin
        err_xfer($sformatf("vec%0d", v), vecs[v].m, vecs[v].n);
      end else begin
        for (int k = 0; k < vecs[v].m * vecs[v].n; k++) mem[k] = 8'(vecs[v].el[k]);
        busy_len = vecs[v].blen;
        rd_lat   = vecs[v].lat;
        load_text(vecs[v].text);
        begin_xfer(vecs[v].id, vecs[v].m, vecs[v].n);
        finish_xfer($sformatf("vec%0d", v));
      end
    end

    // Random matrices against the text model, with stray rd_valid pulses.
    spurious = 1;
    for (int it = 0; it < 8; it++) begin
      int id, m, n;
      id = $urandom_range(0, 15);
      m  = $urandom_range(1, 5);
      n  = $urandom_range(1, 5);
      for (int k = 0; k < 25; k++) begin
        case ($urandom_range(0, 5))
          0:       mem[k] = 8'd0;
          1:       mem[k] = 8'd255;
          2:       mem[k] = 8'd100;
          default: mem[k] = 8'($urandom_range(0, 255));
        endcase
      end
      busy_len = $urandom_range(0, 4);
      rd_lat   = $urandom_range(1, 3);
      model_expect(id, m, n);
      begin_xfer(id, m, n);
      finish_xfer($sformatf("rand%0d", it));
    end
    spurious = 0;

    // Start pulsed mid-transfer, then tx_busy stuck high for 1000 cycles.
    mem[0] = 8'd1; mem[1] = 8'd23; mem[2] = 8'd200; mem[3] = 8'd0;
    busy_len = 10;
    rd_lat   = 1;
    load_text("M3 2x2|1 23|200 0|");
    begin_xfer(3, 2, 2);
    wait_cyc = 0;
    while (got_q.size() < 5 && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("stall_reach_timeout", int'(wait_cyc < 2000), 1);
    @(posedge clk); #1;
    matrix_id = 4'd9; dim_m = 3'd5; dim_n = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    force_busy = 1;
    tx_busy    = 1'b1;
    base       = tx_cnt;
    repeat (1000) @(posedge clk);
    #1;
    check("stall_no_tx", tx_cnt - base, 0);
    force_busy = 0;
    tx_busy    = (busy_left > 0);
    finish_xfer("stall");

    // Reset while row 2 of a 3x3 matrix is being sent, then a fresh full transfer.
    for (int k = 0; k < 9; k++) mem[k] = 8'(k * 31);
    busy_len = 2;
    rd_lat   = 2;
    model_expect(5, 3, 3);
    base = rd_cnt;
    begin_xfer(5, 3, 3);
    wait_cyc = 0;
    while (rd_cnt - base < 7 && wait_cyc < 2000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("reset_reach_timeout", int'(wait_cyc < 2000), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset_tx_start", int'(tx_start), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_rd_en", int'(rd_en), 0);
    rd_out = 0; busy_left = 0; start_seen = 0; tx_busy = 1'b0; rd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin_xfer(5, 3, 3);
    finish_xfer("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
